dec_key_schedule: RTL and testbench

Iterative AES-128 key expander that sits directly upstream of the decryption round datapath and supplies its `roundKey` operand. It accepts a 128-bit cipher key and computes all 11 round keys, one per cycle, into an internal buffer. It then delivers them in reverse order (round 10 down to round 0) over a valid/request handshake, which is the order an inverse cipher consumes them. Keys are retained after delivery, so the same schedule can be replayed without re-expansion.

---
 rtl/dec_key_schedule_if.sv | 28 ++
 rtl/dec_key_schedule.sv | 180 ++++++++++++++++++
 tb/tb_dec_key_schedule.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dec_key_schedule_if.sv
// Key load / round-key delivery bundle for dec_key_schedule.
interface dec_key_schedule_if;
  localparam int unsigned KEY_W = 128;
  localparam int unsigned IDX_W = 4;

  logic             key_valid;
  logic [KEY_W-1:0] key;
  logic             key_ready;
  logic             replay;
  logic             busy;
  logic             rk_valid;
  logic             rk_req;
  logic [KEY_W-1:0] round_key;
  logic [IDX_W-1:0] round_idx;
  logic             done;

  // Driver of keys and consumer of round keys
  modport master (
    output key_valid, key, replay, rk_req,
    input  key_ready, busy, rk_valid, round_key, round_idx, done
  );

  // The key schedule block itself
  modport slave (
    input  key_valid, key, replay, rk_req,
    output key_ready, busy, rk_valid, round_key, round_idx, done
  );
endinterface

// File: rtl/dec_key_schedule.sv
// Iterative AES-128 key expander; serves round keys 10..0 to an inverse cipher.
module dec_key_schedule #(
  parameter int unsigned NR = 10
) (
  input logic               clk,
  input logic               rst_n,
  dec_key_schedule_if.slave ks
);
  localparam int unsigned KEY_W = 128;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned NK    = NR + 1;

  typedef enum logic [1:0] {IDLE, EXPAND, SERVE} state_e;

  state_e             state_q, state_d;
  logic [KEY_W-1:0]   rk_q [NK];
  logic [KEY_W-1:0]   rk_d [NK];
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               stored_q, stored_d;
  logic               key_ready_q, key_ready_d;
  logic               busy_q, busy_d;
  logic               rk_valid_q, rk_valid_d;
  logic               done_q, done_d;
  logic [KEY_W-1:0]   round_key_q, round_key_d;
  logic [IDX_W-1:0]   round_idx_q, round_idx_d;
  logic               hs_c;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse (a^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] base;
    r    = 8'h01;
    base = a;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [IDX_W-1:0] i);
    logic [7:0] rc;
    case (i)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // One AES-128 expansion round: rk[i] from rk[i-1]
  function automatic logic [KEY_W-1:0] expand_step(input logic [KEY_W-1:0] prev,
                                                   input logic [7:0] rc);
    logic [31:0] temp, n0, n1, n2, n3;
    temp = sub_word({prev[23:0], prev[31:24]}) ^ {rc, 24'h000000};
    n0   = prev[127:96] ^ temp;
    n1   = prev[95:64]  ^ n0;
    n2   = prev[63:32]  ^ n1;
    n3   = prev[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  assign hs_c = (state_q == SERVE) & ks.rk_req;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; key_valid wins over replay, replay needs a stored schedule
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ks.key_valid)                state_d = EXPAND;
        else if (ks.replay && stored_q)  state_d = SERVE;
      end
      EXPAND: if (cnt_q == IDX_W'(NR))   state_d = SERVE;
      SERVE:  if (hs_c && idx_q == '0)   state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // Datapath updates and next values of the registered outputs
  always_comb begin
    rk_d     = rk_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    stored_d = stored_q;
    unique case (state_q)
      IDLE: begin
        if (ks.key_valid) begin
          rk_d[0] = ks.key;
          cnt_d   = IDX_W'(1);
        end else if (ks.replay && stored_q) begin
          idx_d = IDX_W'(NR);
        end
      end
      EXPAND: begin
        rk_d[cnt_q] = expand_step(rk_q[cnt_q - IDX_W'(1)], rcon(cnt_q));
        cnt_d       = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(NR)) begin
          stored_d = 1'b1;
          idx_d    = IDX_W'(NR);
          cnt_d    = '0;
        end
      end
      SERVE: if (hs_c && idx_q != '0) idx_d = idx_q - IDX_W'(1);
      default: ;
    endcase
    key_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    rk_valid_d  = (state_d == SERVE);
    round_idx_d = rk_valid_d ? idx_d : '0;
    round_key_d = rk_valid_d ? rk_d[idx_d] : '0;
    done_d      = hs_c && (idx_q == '0);
  end

  // Key buffer, counters and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NK; k++) rk_q[k] <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      stored_q    <= 1'b0;
      key_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rk_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      round_key_q <= '0;
      round_idx_q <= '0;
    end else begin
      rk_q        <= rk_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stored_q    <= stored_d;
      key_ready_q <= key_ready_d;
      busy_q      <= busy_d;
      rk_valid_q  <= rk_valid_d;
      done_q      <= done_d;
      round_key_q <= round_key_d;
      round_idx_q <= round_idx_d;
    end
  end

  assign ks.key_ready = key_ready_q;
  assign ks.busy      = busy_q;
  assign ks.rk_valid  = rk_valid_q;
  assign ks.done      = done_q;
  assign ks.round_key = round_key_q;
  assign ks.round_idx = round_idx_q;
endmodule

// File: tb/tb_dec_key_schedule.sv
// Self-checking bench for dec_key_schedule against a word-level AES-128 key expansion model.
module tb_dec_key_schedule;
  localparam logic [127:0] KEY1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY2   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk = 1'b0;
  logic rst_n;
  dec_key_schedule_if bus ();

  dec_key_schedule #(.NR(10)) dut (.clk(clk), .rst_n(rst_n), .ks(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0]   sbox_tab [256];
  logic [127:0] ref_rk [11];
  logic [127:0] obs [11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // S-box via the 3 / 1/3 generator walk over GF(2^8)
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    sbox_tab[0] = 8'h63;
    do begin
      p = p ^ 8'(p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ 8'(q << 1);
      q = q ^ 8'(q << 2);
      q = q ^ 8'(q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_tab[p] = x ^ 8'h63;
    end while (p != 8'h01);
  endtask

  function automatic logic [31:0] ref_subw(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // Textbook 44-word expansion, grouped into 11 round keys
  task automatic gen_ref(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = ref_subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = 8'({rc, 1'b0}) ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Pulse rst_n mid-cycle and check every output is at its reset value before any edge
  task automatic async_reset_check(input string where);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.key_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rk_valid !== 1'b0 ||
        bus.done !== 1'b0 || bus.round_key !== '0 || bus.round_idx !== '0) begin
      bad++;
      $display("FAIL reset_%s: ready=%b busy=%b valid=%b done=%b key=%h idx=%0d, want 1 0 0 0 0 0",
               where, bus.key_ready, bus.busy, bus.rk_valid, bus.done, bus.round_key, bus.round_idx);
    end
    #3 rst_n = 1'b1;
  endtask

  task automatic replay_ignored(input string where);
    bus.replay = 1'b1;
    tick();
    bus.replay = 1'b0;
    tick();
    total++;
    if (bus.busy !== 1'b0 || bus.rk_valid !== 1'b0) begin
      bad++;
      $display("FAIL replay_ignored_%s: busy=%b valid=%b, want 0 0", where, bus.busy, bus.rk_valid);
    end
  endtask

  // Offer a key in IDLE and check acceptance and the 10-cycle latency to rk_valid
  task automatic load_key(input logic [127:0] k, input bit noise, input bit with_replay);
    int lat;
    bus.key       = k;
    bus.key_valid = 1'b1;
    bus.replay    = with_replay;
    tick();
    bus.replay = 1'b0;
    if (noise) bus.key = KEY2;
    else       bus.key_valid = 1'b0;
    total++;
    if (bus.key_ready !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL accept: ready=%b busy=%b, want 0 1", bus.key_ready, bus.busy);
    end
    lat = 0;
    while (bus.rk_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    total++;
    if (lat != 10) begin
      bad++;
      $display("FAIL latency: got %0d cycles, want 10", lat);
    end
  endtask

  // Consume all 11 keys, checking order, values and stability; then check done
  task automatic serve_check(input logic [127:0] k, input bit rand_req, input bit noise);
    int exp_idx;
    int cyc;
    bit req;
    gen_ref(k);
    exp_idx = 10;
    cyc     = 0;
    while (exp_idx >= 0 && cyc < 400) begin
      total++;
      if (bus.rk_valid !== 1'b1 || bus.round_idx !== 4'(exp_idx) ||
          bus.round_key !== ref_rk[exp_idx] || bus.key_ready !== 1'b0 || bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL serve: valid=%b idx=%0d key=%h ready=%b busy=%b, want valid=1 idx=%0d key=%h ready=0 busy=1",
                 bus.rk_valid, bus.round_idx, bus.round_key, bus.key_ready, bus.busy,
                 exp_idx, ref_rk[exp_idx]);
      end
      req = rand_req ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.rk_req = req;
      if (noise) begin
        bus.key_valid = 1'b1;
        bus.key       = KEY2;
      end
      if (req) obs[exp_idx] = bus.round_key;
      tick();
      if (req) exp_idx--;
      cyc++;
    end
    bus.key_valid = 1'b0;
    bus.rk_req    = 1'b0;
    total++;
    if (bus.done !== 1'b1 || bus.rk_valid !== 1'b0 || bus.key_ready !== 1'b1 ||
        bus.busy !== 1'b0 || bus.round_key !== '0 || bus.round_idx !== '0) begin
      bad++;
      $display("FAIL done_pulse: done=%b valid=%b ready=%b busy=%b key=%h idx=%0d, want 1 0 1 0 0 0",
               bus.done, bus.rk_valid, bus.key_ready, bus.busy, bus.round_key, bus.round_idx);
    end
    tick();
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("FAIL done_width: done=%b, want 0", bus.done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.key_valid = 1'b0;
    bus.key       = '0;
    bus.replay    = 1'b0;
    bus.rk_req    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.key_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rk_valid !== 1'b0 ||
        bus.done !== 1'b0 || bus.round_key !== '0 || bus.round_idx !== '0) begin
      bad++;
      $display("FAIL reset_state: ready=%b busy=%b valid=%b done=%b key=%h idx=%0d, want 1 0 0 0 0 0",
               bus.key_ready, bus.busy, bus.rk_valid, bus.done, bus.round_key, bus.round_idx);
    end
    #3 rst_n = 1'b1;
    tick();
    replay_ignored("before_load");
  endtask

  task automatic test_fips();
    bus.rk_req = 1'b1;
    load_key(KEY1, 1'b0, 1'b0);
    serve_check(KEY1, 1'b0, 1'b0);
    total++;
    if (obs[10] !== K1_R10 || obs[1] !== K1_R1 || obs[0] !== KEY1) begin
      bad++;
      $display("FAIL fips_vectors: r10=%h r1=%h r0=%h, want %h %h %h",
               obs[10], obs[1], obs[0], K1_R10, K1_R1, KEY1);
    end
  endtask

  task automatic test_stall();
    load_key(KEY1, 1'b0, 1'b0);
    serve_check(KEY1, 1'b1, 1'b0);
  endtask

  task automatic test_replay();
    bus.replay = 1'b1;
    tick();
    bus.replay = 1'b0;
    total++;
    if (bus.rk_valid !== 1'b1 || bus.round_idx !== 4'd10 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL replay_latency: valid=%b idx=%0d busy=%b, want 1 10 1",
               bus.rk_valid, bus.round_idx, bus.busy);
    end
    serve_check(KEY1, 1'b1, 1'b0);
  endtask

  task automatic test_ignored();
    load_key(KEY1, 1'b1, 1'b0);
    serve_check(KEY1, 1'b1, 1'b1);
    load_key(KEY2, 1'b0, 1'b1);
    total++;
    if (bus.round_key !== K2_R10 || bus.round_idx !== 4'd10) begin
      bad++;
      $display("FAIL key_beats_replay: key=%h idx=%0d, want %h 10", bus.round_key, bus.round_idx, K2_R10);
    end
    serve_check(KEY2, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [127:0] k;
    int n;
    bus.key       = KEY1;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    repeat (5) tick();
    async_reset_check("expand");
    tick();
    replay_ignored("after_expand_reset");
    k = {$urandom, $urandom, $urandom, $urandom};
    load_key(k, 1'b0, 1'b0);
    bus.rk_req = 1'b1;
    n = 0;
    while (bus.round_idx !== 4'd4 && n < 30) begin
      tick();
      n++;
    end
    bus.rk_req = 1'b0;
    total++;
    if (bus.round_idx !== 4'd4) begin
      bad++;
      $display("FAIL reach_idx4: idx=%0d, want 4", bus.round_idx);
    end
    async_reset_check("serve");
    tick();
    replay_ignored("after_serve_reset");
    k = {$urandom, $urandom, $urandom, $urandom};
    load_key(k, 1'b0, 1'b0);
    serve_check(k, 1'b1, 1'b0);
  endtask

  task automatic test_random_keys();
    logic [127:0] k;
    for (int t = 0; t < 4; t++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      load_key(k, 1'b0, 1'b0);
      serve_check(k, 1'b1, 1'b0);
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_stall();
    test_replay();
    test_ignored();
    test_reset_mid();
    test_random_keys();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
